// File: rtl/uart_baud_clock_gen_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART baud constants. The Baud Rate Divisor register and the serial
// clock generator both use these, so the clamp floor and the reset divisor
// cannot drift apart.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef logic [7:0] baud_div_t;

    localparam baud_div_t BAUD_DIV_MIN   = 8'd5;
    localparam baud_div_t BAUD_DIV_RESET = 8'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } baud_state_t;

endpackage

// File: rtl/uart_baud_clock_gen_if.sv
// -----------------------------------------------------------------------------
// uart_baud_clock_gen_if
// Control/status bundle between the divisor register side (master) and the
// serial clock generator (slave).
//   enable    master -> slave   1 = generate serial clock
//   divisor   master -> slave   divisor, sampled only at a start
//   tick      slave  -> master  one-clk end-of-bit strobe
//   sclk      slave  -> master  serial clock, low first half / high second half
//   running   slave  -> master  generator active, shadow divisor valid
//   half_tick slave  -> master  mid-bit strobe (only with UART_HALF_TICK_EN)
// Optional feature macro: UART_HALF_TICK_EN
// -----------------------------------------------------------------------------
interface uart_baud_clock_gen_if #(
    parameter int DIV_W = 8
);

    logic             enable;
    logic [DIV_W-1:0] divisor;
    logic             tick;
    logic             sclk;
    logic             running;
`ifdef UART_HALF_TICK_EN
    logic             half_tick;
`endif

    modport master (
        output enable,
        output divisor,
        input  tick,
        input  sclk,
`ifdef UART_HALF_TICK_EN
        input  half_tick,
`endif
        input  running
    );

    modport slave (
        input  enable,
        input  divisor,
        output tick,
        output sclk,
`ifdef UART_HALF_TICK_EN
        output half_tick,
`endif
        output running
    );

endinterface

// File: rtl/uart_baud_clock_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_clock_gen
// Serial clock generator fed by the UART Baud Rate Divisor register. Once
// enabled it latches a clamped copy of the divisor (shadow) and produces one
// bit period every shadow clk cycles: a free-running sclk and a tick strobe
// at the end of every period, feeding the TX/RX shifters.
//
// Ports
//   clk     in   system clock, all state on posedge
//   reset   in   asynchronous, active-high reset
//   bus     uart_baud_clock_gen_if.slave
//           enable/divisor in; tick/sclk/running(/half_tick) out
//
// Optional feature macro: UART_HALF_TICK_EN adds the half_tick strobe
// (receiver mid-bit sample point). Without it no half_tick logic exists.
//
// All outputs come straight from flops; nothing combinational from inputs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | generator stopped; outputs idle, waiting for enable
// ST_RUN  | counting 0..shadow-1, emitting sclk/tick from the shadow
// -----------------------------------------------------------------------------
module uart_baud_clock_gen
    import uart_pkg::*;
#(
    parameter int               DIV_W   = 8,
    parameter logic [DIV_W-1:0] DIV_MIN = DIV_W'(BAUD_DIV_MIN)
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_baud_clock_gen_if.slave        bus
);

    baud_state_t      state_q,  state_d;
    logic [DIV_W-1:0] count_q,  count_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             tick_q,   tick_d;
    logic             sclk_q,   sclk_d;
`ifdef UART_HALF_TICK_EN
    logic             half_q,   half_d;
`endif

    logic [DIV_W-1:0] half_point;
    logic             at_last;

    // Shadow is always >= DIV_MIN, so these never underflow and the counter
    // never reaches shadow, keeping it inside DIV_W bits.
    assign half_point = shadow_q >> 1;
    assign at_last    = (count_q == (shadow_q - DIV_W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            shadow_q <= DIV_MIN;
            tick_q   <= 1'b0;
            sclk_q   <= 1'b0;
`ifdef UART_HALF_TICK_EN
            half_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            tick_q   <= tick_d;
            sclk_q   <= sclk_d;
`ifdef UART_HALF_TICK_EN
            half_q   <= half_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        count_d  = '0;
        tick_d   = 1'b0;
        sclk_d   = 1'b0;
`ifdef UART_HALF_TICK_EN
        half_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    // Fresh start: sample and clamp the divisor. Count 0 is
                    // always in the low half, so sclk stays 0 here.
                    state_d  = ST_RUN;
                    shadow_d = (bus.divisor < DIV_MIN) ? DIV_MIN : bus.divisor;
                end
            end

            ST_RUN: begin
                if (!bus.enable) begin
                    // Stop drops everything, including any partial period.
                    state_d = ST_IDLE;
                end else begin
                    if (at_last) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                    end else begin
                        count_d = count_q + DIV_W'(1);
                    end
                    sclk_d = (count_d >= half_point);
`ifdef UART_HALF_TICK_EN
                    half_d = (count_q == (half_point - DIV_W'(1)));
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.tick    = tick_q;
    assign bus.sclk    = sclk_q;
    assign bus.running = (state_q == ST_RUN);
`ifdef UART_HALF_TICK_EN
    assign bus.half_tick = half_q;
`endif

endmodule

// File: tb/tb_uart_baud_clock_gen.sv
module tb_uart_baud_clock_gen;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    uart_baud_clock_gen_if bif ();

    uart_baud_clock_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Advance n clocks, sampling point is 1 time unit after each posedge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic stop_gen;
        bif.enable = 1'b0;
        step(1);
    endtask

    // Number of clocks until tick is seen; -1 if the bound expires.
    task automatic wait_tick(input int bound, output int n);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        while (k < bound && !seen) begin
            step(1);
            k++;
            if (bif.tick === 1'b1) seen = 1'b1;
        end
        n = seen ? k : -1;
    endtask

    task automatic test_reset;
        bif.enable  = 1'b0;
        bif.divisor = 8'd5;
        #1 reset = 1'b1;
        #2;
        checks++;
        if ({bif.running, bif.tick, bif.sclk} !== 3'b000) begin
            failures++;
            $display("FAIL reset_state got=%b want=000", {bif.running, bif.tick, bif.sclk});
        end
        step(2);
        reset = 1'b0;
        step(3);
        checks++;
        if ({bif.running, bif.tick, bif.sclk} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset got=%b want=000", {bif.running, bif.tick, bif.sclk});
        end
    endtask

    // Waveform check for an effective shadow of 5: sclk 0,0,1,1,1 per period,
    // tick at count 0 of each following period.
    task automatic test_wave5(input string name, input logic [7:0] div);
        logic [4:0] sclk_pat;
        int         bad;
        sclk_pat = 5'b11100;
        stop_gen();
        bif.divisor = div;
        bif.enable  = 1'b1;
        step(1);
        checks++;
        if ({bif.running, bif.tick, bif.sclk} !== 3'b100) begin
            failures++;
            $display("FAIL %s_start got=%b want=100", name, {bif.running, bif.tick, bif.sclk});
        end
        bad = 0;
        for (int i = 1; i <= 15; i++) begin
            step(1);
            if (bif.sclk !== sclk_pat[i % 5] || bif.tick !== (i % 5 == 0)) begin
                bad++;
                $display("FAIL %s_cycle%0d got sclk=%b tick=%b want sclk=%b tick=%b",
                         name, i, bif.sclk, bif.tick, sclk_pat[i % 5], (i % 5 == 0));
            end
        end
        checks++;
        if (bad != 0) failures++;
    endtask

    task automatic test_divisor_lock;
        int n;
        stop_gen();
        bif.divisor = 8'd8;
        bif.enable  = 1'b1;
        step(1);
        step(3);
        bif.divisor = 8'd20;
        wait_tick(100, n);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL lock_first_tick got=%0d want=5", n);
        end
        wait_tick(100, n);
        checks++;
        if (n !== 8) begin
            failures++;
            $display("FAIL lock_period got=%0d want=8", n);
        end
        bif.enable = 1'b0;
        step(1);
        bif.enable = 1'b1;
        step(1);
        wait_tick(100, n);
        checks++;
        if (n !== 20) begin
            failures++;
            $display("FAIL reload_first_tick got=%0d want=20", n);
        end
        wait_tick(100, n);
        checks++;
        if (n !== 20) begin
            failures++;
            $display("FAIL reload_period got=%0d want=20", n);
        end
    endtask

    task automatic test_stop_mid;
        int ticks;
        stop_gen();
        bif.divisor = 8'd8;
        bif.enable  = 1'b1;
        step(1);
        step(3);
        bif.enable = 1'b0;
        step(1);
        checks++;
        if ({bif.running, bif.tick, bif.sclk} !== 3'b000) begin
            failures++;
            $display("FAIL stop_state got=%b want=000", {bif.running, bif.tick, bif.sclk});
        end
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bif.tick === 1'b1 || bif.running === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 0) begin
            failures++;
            $display("FAIL stop_quiet got=%0d want=0", ticks);
        end
    endtask

    task automatic test_async_reset;
        int n;
        stop_gen();
        bif.divisor = 8'd5;
        bif.enable  = 1'b1;
        step(1);
        step(3);
        checks++;
        if (bif.sclk !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_sclk got=%b want=1", bif.sclk);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bif.running, bif.tick, bif.sclk} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset got=%b want=000", {bif.running, bif.tick, bif.sclk});
        end
        bif.enable = 1'b0;
        step(1);
        reset = 1'b0;
        step(2);
        checks++;
        if (bif.running !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle got=%b want=0", bif.running);
        end
        bif.enable = 1'b1;
        step(1);
        wait_tick(50, n);
        checks++;
        if (bif.running !== 1'b1 || n !== 5) begin
            failures++;
            $display("FAIL post_reset_restart got running=%b n=%0d want running=1 n=5", bif.running, n);
        end
    endtask

    task automatic test_boundaries;
        int n;
        stop_gen();
        bif.divisor = 8'd0;
        bif.enable  = 1'b1;
        step(1);
        wait_tick(50, n);
        checks++;
        if (n !== 5) begin
            failures++;
            $display("FAIL clamp0_period got=%0d want=5", n);
        end
        stop_gen();
        bif.divisor = 8'd255;
        bif.enable  = 1'b1;
        step(1);
        wait_tick(600, n);
        checks++;
        if (n !== 255) begin
            failures++;
            $display("FAIL div255_first got=%0d want=255", n);
        end
        wait_tick(600, n);
        checks++;
        if (n !== 255) begin
            failures++;
            $display("FAIL div255_period got=%0d want=255", n);
        end
        stop_gen();
    endtask

`ifdef UART_HALF_TICK_EN
    task automatic test_half_tick;
        int first_half, first_tick, half_cnt, tick_cnt;
        stop_gen();
        bif.divisor = 8'd10;
        bif.enable  = 1'b1;
        step(1);
        first_half = -1;
        first_tick = -1;
        half_cnt   = 0;
        tick_cnt   = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (bif.half_tick === 1'b1) begin
                half_cnt++;
                if (first_half < 0) first_half = i;
            end
            if (bif.tick === 1'b1) begin
                tick_cnt++;
                if (first_tick < 0) first_tick = i;
            end
        end
        checks++;
        if (first_half != 5 || first_tick != 10 || half_cnt != 1 || tick_cnt != 1) begin
            failures++;
            $display("FAIL half_tick got half@%0d tick@%0d widths %0d/%0d want half@5 tick@10 widths 1/1",
                     first_half, first_tick, half_cnt, tick_cnt);
        end
        stop_gen();
    endtask
`endif

    initial begin
        test_reset();
        test_wave5("div5", 8'd5);
        test_wave5("div2", 8'd2);
        test_divisor_lock();
        test_stop_mid();
        test_async_reset();
        test_boundaries();
`ifdef UART_HALF_TICK_EN
        test_half_tick();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
